fb_scanout_reader: RTL and testbench

Streams the 320x240 on-chip framebuffer (76800 x 32-bit words, single-port, 1-cycle read latency) out as a pixel stream for the display path. The block is the framebuffer's downstream consumer. It acts as the memory's read master: it issues sequential word reads, absorbs the fixed read latency in a small show-ahead FIFO, and presents pixels on a valid/ready interface. Pixels carry start-of-frame and end-of-line tags.

---
 rtl/fb_scanout_reader.sv | 254 +++++++++++++++++++++++++
 tb/tb_fb_scanout_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout_reader.sv
// -----------------------------------------------------------------------------
// fb_scanout_reader
//
// Reads the on-chip framebuffer sequentially, one 32-bit word per pixel, and
// streams the pixels out on a valid/ready interface. The block is the
// framebuffer's read master. A small show-ahead FIFO absorbs the memory's
// fixed 1-cycle read latency. Every pixel carries two tags:
//   - sof: the pixel is word 0 of the frame.
//   - eol: the pixel is the last one of its line.
//
// Read timing
//   - The read decision for a cycle is made from that cycle's mem_grant and
//     credit.
//   - The strobe and address are registered, so they are driven on the
//     following cycle.
//   - Read data returns on the cycle after that and is pushed at the end of
//     it, so a pixel becomes visible 2 cycles after its address is driven.
//
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   start              1-cycle pulse, begins scanout at address 0 (IDLE only)
//   continuous         1: wrap into the next frame; 0: stop after this frame
//   mem_grant          arbiter permits a read
//   mem_address        registered read address
//   mem_chipselect     registered read strobe
//   mem_clken          constant 1
//   mem_readdata       read data, valid 1 cycle after a strobed address
//   pix_data           pixel word (0 when no pixel is available)
//   pix_sof, pix_eol   start-of-frame / end-of-line tags
//   pix_valid          pixel available
//   pix_ready          sink accepts
//   busy               block is not IDLE
//   frame_done         1-cycle pulse after the last pixel of a frame is taken
//   underflow_count    saturating count of RUN cycles in which the sink was
//                      ready but no pixel was available; only present when
//                      FB_SCANOUT_UNDERFLOW_CNT_EN is defined
//
// Configuration
//   FB_SCANOUT_UNDERFLOW_CNT_EN  adds the underflow_count port and counter.
//
// FIFO_DEPTH must be a power of 2 and at least 4.
// -----------------------------------------------------------------------------
module fb_scanout_reader #(
  parameter int NUM_WORDS  = 76800,
  parameter int ADDR_W     = 17,
  parameter int H_PIXELS   = 320,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [31:0]       pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int SUM_W = CNT_W + 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_PIXELS - 1);
  localparam logic [SUM_W-1:0]  DEPTH_SUM = SUM_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Read issue side
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [COL_W-1:0]  col_q, cur_col;
  logic [SUM_W-1:0]  credit_used;
  logic              issue, last_issue;

  // Tag pipeline, aligned with the strobe and then with the returning data
  logic s1_sof, s1_eol;
  logic inflight, s2_sof, s2_eol;

  // Show-ahead FIFO: {eol, sof, data}
  logic [33:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [33:0]      head;
  logic             push, pop;

  // Pixel position within the frame, used to find the frame's last pixel
  logic [ADDR_W-1:0] pop_idx, pop_pos;

  assign push = inflight;
  assign pop  = pix_valid && pix_ready;

  // ---------------------------------------------------------------------------
  // Issue logic
  //
  // The strobe is registered, so a read decided now lands on the bus next
  // cycle. The credit therefore covers every word already on its way:
  //   - words stored in the FIFO,
  //   - the word returning now (inflight),
  //   - the word being strobed now (mem_chipselect).
  // Pops in the same cycle are not credited.
  // ---------------------------------------------------------------------------
  // NOTE: give every always_comb output a default before any branch; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    cur_addr    = (state_q == IDLE) ? '0 : addr_q;
    cur_col     = (state_q == IDLE) ? '0 : col_q;
    credit_used = SUM_W'(fifo_count) + SUM_W'(inflight) + SUM_W'(mem_chipselect);
    issue       = mem_grant && (credit_used < DEPTH_SUM) &&
                  ((state_q == RUN) || ((state_q == IDLE) && start));
    last_issue  = issue && (cur_addr == LAST_ADDR) && !continuous;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so that every register
  // samples pre-edge values, whatever the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = last_issue ? DRAIN : RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (!mem_chipselect && !inflight && (fifo_count == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != IDLE);
    mem_clken = 1'b1;
    pix_valid = (fifo_count != '0);
    head      = fifo_mem[rd_ptr];
    pix_data  = pix_valid ? head[31:0] : '0;
    pix_sof   = pix_valid && head[32];
    pix_eol   = pix_valid && head[33];
    // A sof pixel restarts the position count, so every frame realigns itself.
    pop_pos   = head[32] ? '0 : pop_idx;
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, strobe, tag pipeline, FIFO pointers, frame_done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q         <= '0;
      col_q          <= '0;
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      s1_sof         <= 1'b0;
      s1_eol         <= 1'b0;
      // Clearing inflight drops any word returning in the cycle after reset.
      inflight       <= 1'b0;
      s2_sof         <= 1'b0;
      s2_eol         <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      pop_idx        <= '0;
      frame_done     <= 1'b0;
    end else begin
      if (issue) begin
        addr_q <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
        col_q  <= (cur_col == LAST_COL)   ? '0 : cur_col + 1'b1;
      end else if ((state_q == IDLE) && start) begin
        addr_q <= '0;
        col_q  <= '0;
      end

      mem_chipselect <= issue;
      mem_address    <= issue ? cur_addr : '0;
      s1_sof         <= issue && (cur_addr == '0);
      s1_eol         <= issue && (cur_col == LAST_COL);

      inflight <= mem_chipselect;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      frame_done <= 1'b0;
      if (pop) begin
        frame_done <= (pop_pos == LAST_ADDR);
        pop_idx    <= pop_pos + 1'b1;
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s2_eol, s2_sof, mem_readdata};
  end

  // The credit rule makes a push into a full FIFO impossible.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_count == DEPTH_CNT)));

`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
  // Counting starts only once the run has produced its first pixel, so the
  // pipeline fill after start is not counted as underflow.
  logic seen_pix;

  always_ff @(posedge clk) begin
    if (reset || ((state_q == IDLE) && start)) begin
      underflow_count <= '0;
      seen_pix        <= 1'b0;
    end else begin
      if (pix_valid) seen_pix <= 1'b1;
      if ((state_q == RUN) && seen_pix && pix_ready && !pix_valid &&
          (underflow_count != 16'hFFFF))
        underflow_count <= underflow_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_scanout_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fb_scanout_reader.
//
// The framebuffer is shrunk to 30 lines of 32 pixels. The memory model
// returns a hashed word per address. A reference model predicts the expected
// stream from the pixel's position in the frame alone:
//   - the data word,
//   - the sof and eol tags,
//   - the frame_done timing,
//   - the address sequence.
// Outputs are sampled on the falling clock edge. Inputs change 1 time unit
// after the rising edge.
//
// mem_grant permits the strobe driven on the following cycle, because the
// strobe is a registered output.
// -----------------------------------------------------------------------------
module tb_fb_scanout_reader;

  localparam int NW = 960;
  localparam int AW = 17;
  localparam int HP = 32;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          reset, start, continuous, mem_grant, pix_ready;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_clken;
  logic [31:0]   mem_readdata, pix_data;
  logic          pix_sof, pix_eol, pix_valid, busy, frame_done;
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_count;
`endif

  always #5 clk = ~clk;

  fb_scanout_reader #(
    .NUM_WORDS (NW),
    .ADDR_W    (AW),
    .H_PIXELS  (HP),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .mem_grant     (mem_grant),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .busy          (busy),
    .frame_done    (frame_done)
`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  // Framebuffer content: a distinct, non-zero word per address.
  function automatic logic [31:0] word(int a);
    return (32'(a) + 32'd1) * 32'h9E37_79B1;
  endfunction

  // 1-cycle-latency memory; anything not strobed returns junk.
  always @(posedge clk)
    mem_readdata <= mem_chipselect ? word(int'(mem_address)) : 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int          exp_idx, exp_addr, outst, fd_cnt, pop_cnt, cs_cnt, uf_model;
  bit          fd_due, prev_stall, prev_grant, prev_cont, in_run, seen_pix;
  logic [33:0] prev_pix;

  task automatic clear_model();
    exp_idx    = 0;
    exp_addr   = 0;
    outst      = 0;
    fd_due     = 0;
    prev_stall = 0;
    in_run     = 0;
    seen_pix   = 0;
  endtask

  // Per-cycle observation, run at the falling edge.
  task automatic monitor();
    if (!reset) begin
      check("frame_done", frame_done, fd_due);
      if (frame_done) fd_cnt++;
      fd_due = 0;

      if (mem_chipselect) begin
        cs_cnt++;
        check("strobe_granted", prev_grant, 1);
        check("mem_address", mem_address, exp_addr);
        // The last read of a non-continuous frame moves the block to DRAIN.
        if (exp_addr == NW - 1 && !prev_cont) in_run = 0;
        exp_addr = (exp_addr + 1) % NW;
        outst++;
        check("outstanding_le_depth", outst <= FD, 1);
      end

      if (prev_stall)
        check("stall_hold", {pix_valid, pix_eol, pix_sof, pix_data}, {1'b1, prev_pix});

      if (in_run && seen_pix && pix_ready && !pix_valid && uf_model < 65535) uf_model++;
      if (pix_valid) seen_pix = 1;

      if (pix_valid && pix_ready) begin
        check("pix_data", pix_data, word(exp_idx));
        check("pix_tags", {pix_sof, pix_eol}, {exp_idx == 0, (exp_idx % HP) == HP - 1});
        fd_due  = (exp_idx == NW - 1);
        exp_idx = (exp_idx + 1) % NW;
        outst--;
        pop_cnt++;
      end

      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_eol, pix_sof, pix_data};
    end
    prev_grant = mem_grant;
    prev_cont  = continuous;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  // Leaves the bench in the cycle after start was sampled.
  task automatic do_start(bit cont);
    continuous = cont;
    start      = 1'b1;
    exp_idx    = 0;
    exp_addr   = 0;
    pop_cnt    = 0;
    fd_cnt     = 0;
    uf_model   = 0;
    seen_pix   = 0;
    in_run     = 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("returns_idle", busy, 0);
  endtask

  task automatic wait_frame_done(int budget, output int n);
    n = 0;
    while (!frame_done && n < budget) begin
      tick();
      n++;
    end
    check("frame_done_seen", frame_done, 1);
  endtask

  task automatic run_until_pops(int target, int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("pops_reached", pop_cnt >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, base;
    start      = 1'b0;
    continuous = 1'b0;
    mem_grant  = 1'b1;
    pix_ready  = 1'b1;
    reset      = 1'b1;
    #1;
    fd_cnt = 0;
    pop_cnt = 0;
    cs_cnt = 0;
    uf_model = 0;
    clear_model();
    do_reset();
    do_reset();

    // Reset values
    check("idle_outputs",
          {mem_address, mem_chipselect, pix_valid, pix_data, pix_sof, pix_eol, busy, frame_done},
          64'd0);
    check("mem_clken", mem_clken, 1);

    // Single frame at full rate, with first-pixel latency
    do_start(0);
    check("first_strobe", {busy, mem_chipselect, mem_address}, {2'b11, 17'd0});
    check("valid_n1", pix_valid, 0);
    tick();
    check("valid_n2", pix_valid, 0);
    tick();
    check("valid_n3", {pix_valid, pix_sof, pix_data}, {2'b11, word(0)});
    wait_frame_done(NW + 20, n);
    check("full_rate_frame_cycles", n, NW);
    wait_idle(20);
    check("frame1_pixels", pop_cnt, NW);
    check("frame1_done_pulses", fd_cnt, 1);

    // Reset mid-run, then restart from pixel 0
    do_start(0);
    run_until_pops(500, 2 * NW);
    do_reset();
    check("reset_midrun", {pix_valid, mem_chipselect, busy}, 3'b000);
    tick();
    check("reset_discard", {pix_valid, busy}, 2'b00);
    do_start(0);
    n = 0;
    while (!pix_valid && n < 10) begin
      tick();
      n++;
    end
    check("restart_first_pixel", {pix_valid, pix_sof, pix_data}, {2'b11, word(0)});
    wait_idle(NW + 50);
    check("restart_pixels", pop_cnt, NW);

    // Backpressure: sink ready about 30% of cycles
    do_start(0);
    n = 0;
    while (pop_cnt < NW && n < 8 * NW) begin
      pix_ready = ($urandom_range(0, 99) < 30);
      tick();
      n++;
    end
    pix_ready = 1'b1;
    wait_idle(50);
    check("backpressure_pixels", pop_cnt, NW);
    check("backpressure_done_pulses", fd_cnt, 1);

    // Arbitration: grant withheld for 20 cycles mid-frame
    do_start(0);
    run_until_pops(300, 2 * NW);
    mem_grant = 1'b0;
    tick();
    base = cs_cnt;
    repeat (19) tick();
    check("no_strobe_in_window", cs_cnt - base, 0);
    check("fifo_drained", pix_valid, 0);
    mem_grant = 1'b1;
    wait_idle(NW + 50);
    check("arbitration_pixels", pop_cnt, NW);

    // Continuous: two frames back to back with no bubble at the wrap
    do_start(1);
    wait_frame_done(NW + 20, n);
    check("wrap_first_done_cycles", n, NW + 2);
    continuous = 1'b0;
    tick();
    wait_frame_done(NW + 20, n);
    check("wrap_no_bubble_cycles", n, NW - 1);
    wait_idle(20);
    check("wrap_pixels", pop_cnt, 2 * NW);
    check("wrap_done_pulses", fd_cnt, 2);

`ifdef FB_SCANOUT_UNDERFLOW_CNT_EN
    // Underflow: grant alternates each cycle, sink always ready
    do_start(0);
    n = 0;
    while (busy && n < 6 * NW) begin
      mem_grant = ~mem_grant;
      tick();
      n++;
    end
    mem_grant = 1'b1;
    check("underflow_returns_idle", busy, 0);
    check("underflow_count", underflow_count, uf_model);
    check("underflow_pixels", pop_cnt, NW);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
